// File: rtl/pll_reset_sequencer_pkg.sv
// Shared state encoding and default timing constants for the PLL reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pll_reset_sequencer_pkg;

    // Default timing, sized for a 50 MHz board reference clock.
    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES         = 3;

    // Sequencer states, kept as plain constants so older tools read them unchanged.
    typedef logic [2:0] state_t;
    localparam state_t ST_RESET_PLL = 3'd0;
    localparam state_t ST_WAIT_LOCK = 3'd1;
    localparam state_t ST_STABLE    = 3'd2;
    localparam state_t ST_RUN       = 3'd3;
    localparam state_t ST_FAULT     = 3'd4;

    // Largest of three timing parameters; sizes the shared cycle counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into the refclk domain.
// Latency: 2 clock cycles from input change to output change.
// Backpressure: none; samples every cycle.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: shift the raw input down the two-stage chain.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stages, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock qualification and system reset release, with retry/fault handling.
// Latency: outputs registered; lock loss in RUN reaches sys_rst in 3 cycles (2 sync + 1 state).
// Backpressure: none; relock_req is a single-cycle request honoured only in RUN.
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                             refclk,
    input  logic                             rst,
    input  logic                             pll_locked,
    input  logic                             relock_req,
    output logic                             pll_rst,
    output logic                             sys_rst,
    output logic                             ready,
    output logic                             fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
    output logic [7:0]                       lol_cnt
);

    localparam int RCW   = $clog2(MAX_RETRIES + 1);
    localparam int CNT_W = $clog2(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                       LOCK_STABLE_CYCLES) + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RCW-1:0]   RETRY_LIMIT = RCW'(MAX_RETRIES);

    logic             locked_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RCW-1:0]   retry_q, retry_d;
    logic [RCW-1:0]   retry_inc;
    logic [7:0]       lol_q, lol_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    assign retry_inc = retry_q + RCW'(1);

    // Next state, shared counter, retry and loss-of-lock bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        lol_d   = lol_q;
        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_RESET_PLL;
                end
            end
            ST_STABLE: begin
                // Any dropout restarts qualification with a fresh timeout window.
                if (!locked_s)                 state_d = ST_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q;
                // Loss of lock wins over a coincident relock request.
                if (!locked_s) begin
                    lol_d   = (lol_q != 8'hFF) ? lol_q + 8'd1 : lol_q;
                    state_d = ST_RESET_PLL;
                end else if (relock_req) begin
                    state_d = ST_RESET_PLL;
                end
            end
            ST_FAULT: begin
                cnt_d = cnt_q;
            end
            default: state_d = ST_RESET_PLL;
        endcase
        if (state_d != state_q) cnt_d = '0;
        if (state_d == ST_RUN)  retry_d = '0;
    end

    // Outputs decoded from the next state so they are registered yet track the state.
    always_comb begin
        pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
        sys_rst_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
        fault_d   = (state_d == ST_FAULT);
    end

    // State and output registers with synchronous reset back to RESET_PLL.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            lol_q     <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            lol_q     <= lol_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;
    assign lol_cnt   = lol_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with small timing parameters.
// Latency: expectations derived from the sequencing rules (pulse, timeout, qualify, 2-flop sync).
// Backpressure: n/a.
module tb_pll_reset_sequencer;

    localparam int RP  = 4;
    localparam int LT  = 100;
    localparam int LS  = 16;
    localparam int MR  = 2;
    localparam int RCW = $clog2(MR + 1);
    localparam int LIM = 1000;

    logic           refclk = 1'b0;
    logic           rst;
    logic           pll_locked;
    logic           relock_req;
    logic           pll_rst;
    logic           sys_rst;
    logic           ready;
    logic           fault;
    logic [RCW-1:0] retry_cnt;
    logic [7:0]     lol_cnt;

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    int exp_lol = 0;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (RP),
        .LOCK_TIMEOUT_CYCLES (LT),
        .LOCK_STABLE_CYCLES  (LS),
        .MAX_RETRIES         (MR)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .lol_cnt    (lol_cnt)
    );

    always #10 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock: step past the edge, then watch the reset-ordering invariant.
    task automatic tick();
        @(posedge refclk);
        #1;
        if (pll_rst === 1'b1 && sys_rst !== 1'b1) viol++;
    endtask

    task automatic chk_reset_vals(input string where);
        chk({where, "_pll_rst"}, 32'(pll_rst), 1);
        chk({where, "_sys_rst"}, 32'(sys_rst), 1);
        chk({where, "_ready"},   32'(ready),   0);
        chk({where, "_fault"},   32'(fault),   0);
        chk({where, "_retry"},   32'(retry_cnt), 0);
        chk({where, "_lol"},     32'(lol_cnt), 0);
    endtask

    // Samples with pll_rst high, starting from the current sample.
    task automatic measure_high(output int n);
        n = 0;
        while (pll_rst === 1'b1 && n < LIM) begin
            n++;
            tick();
        end
    endtask

    // Samples with pll_rst low; optionally pulses relock_req at a given offset.
    task automatic measure_low(input int relock_at, output int n);
        n = 0;
        while (pll_rst === 1'b0 && n < LIM) begin
            relock_req = (n == relock_at);
            n++;
            tick();
        end
        relock_req = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < LIM) begin
            tick();
            n++;
        end
    endtask

    // From the first WAIT_LOCK sample: raise lock after k cycles, expect ready LS+3 later.
    task automatic bring_up(input int k);
        int lat;
        repeat (k) tick();
        pll_locked = 1'b1;
        wait_ready(lat);
        chk("ready_latency", 32'(lat), 32'(LS + 3));
        chk("run_sys_rst", 32'(sys_rst), 0);
        chk("run_pll_rst", 32'(pll_rst), 0);
    endtask

    // From RUN: drop lock, optionally with relock on the cycle the synced lock falls.
    task automatic lose_lock(input bit with_relock);
        int n;
        pll_locked = 1'b0;
        tick();
        tick();
        chk("lol_early_sys_rst", 32'(sys_rst), 0);
        if (with_relock) relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        exp_lol = (exp_lol < 255) ? exp_lol + 1 : 255;
        chk("lol_sys_rst", 32'(sys_rst), 1);
        chk("lol_ready", 32'(ready), 0);
        chk("lol_cnt", 32'(lol_cnt), 32'(exp_lol));
        measure_high(n);
        chk("lol_pulse_len", 32'(n), 32'(RP));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int j;
        int stuck;

        rst = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (3) tick();
        chk_reset_vals("por");

        // Normal bring-up, lock 10 cycles after pll_rst falls.
        rst = 1'b0;
        measure_high(n);
        chk("boot_pulse_len", 32'(n), 32'(RP));
        chk("boot_retry", 32'(retry_cnt), 0);
        bring_up(10);

        // Relock request while running.
        repeat ($urandom_range(1, 10)) tick();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk("relock_pll_rst", 32'(pll_rst), 1);
        chk("relock_ready", 32'(ready), 0);
        chk("relock_lol", 32'(lol_cnt), 32'(exp_lol));
        measure_high(n);
        chk("relock_pulse_len", 32'(n), 32'(RP));
        wait_ready(n);
        chk("relock_back_ready", 32'(ready), 1);

        // Loss of lock alone, then with a coincident relock request.
        lose_lock(1'b0);
        bring_up($urandom_range(0, 80));
        lose_lock(1'b1);
        bring_up($urandom_range(0, 80));

        // One-cycle lock glitch during qualification: first at count 8, then random.
        for (int g = 0; g < 2; g++) begin
            lose_lock(1'b0);
            repeat ($urandom_range(0, 60)) tick();
            pll_locked = 1'b1;
            j = (g == 0) ? 9 : $urandom_range(1, 15);
            repeat (j) tick();
            pll_locked = 1'b0;
            tick();
            pll_locked = 1'b1;
            chk("glitch_ready_low", 32'(ready), 0);
            chk("glitch_retry", 32'(retry_cnt), 0);
            wait_ready(n);
            chk("glitch_ready_latency", 32'(n), 32'(LS + 3));
        end

        // Two timeouts lead to fault; relock in WAIT_LOCK is ignored.
        lose_lock(1'b0);
        measure_low($urandom_range(3, 60), n);
        chk("timeout1_len", 32'(n), 32'(LT));
        chk("timeout1_retry", 32'(retry_cnt), 1);
        chk("timeout1_fault", 32'(fault), 0);
        measure_high(n);
        chk("retry_pulse_len", 32'(n), 32'(RP));
        measure_low(-1, n);
        chk("timeout2_len", 32'(n), 32'(LT));
        chk("fault_flag", 32'(fault), 1);
        chk("fault_retry", 32'(retry_cnt), 2);
        chk("fault_sys_rst", 32'(sys_rst), 1);
        chk("fault_ready", 32'(ready), 0);
        stuck = 0;
        repeat ($urandom_range(50, 200)) begin
            pll_locked = 1'($urandom);
            relock_req = 1'($urandom);
            tick();
            if (pll_rst !== 1'b1 || fault !== 1'b1) stuck++;
        end
        relock_req = 1'b0;
        chk("fault_hold", 32'(stuck), 0);

        // Reset out of FAULT.
        pll_locked = 1'b0;
        rst = 1'b1;
        tick();
        chk_reset_vals("rst_in_fault");
        exp_lol = 0;
        rst = 1'b0;
        measure_high(n);
        chk("after_fault_pulse", 32'(n), 32'(RP));
        bring_up($urandom_range(0, 80));

        // Reset while qualifying lock.
        lose_lock(1'b0);
        repeat ($urandom_range(0, 40)) tick();
        pll_locked = 1'b1;
        repeat (3 + $urandom_range(0, 10)) tick();
        rst = 1'b1;
        tick();
        chk_reset_vals("rst_in_stable");
        exp_lol = 0;
        pll_locked = 1'b0;
        rst = 1'b0;
        measure_high(n);
        chk("after_stable_pulse", 32'(n), 32'(RP));
        bring_up($urandom_range(0, 20));

        // 300 loss-of-lock events, some with coincident relock; counter saturates.
        for (int i = 0; i < 300; i++) begin
            lose_lock($urandom_range(0, 3) == 0);
            bring_up($urandom_range(0, 20));
        end
        chk("lol_saturated", 32'(lol_cnt), 255);

        chk("sys_rst_under_pll_rst", 32'(viol), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
